multi_road_traffic_ctrl: RTL and testbench
==========================================

MULTI_ROAD_TRAFFIC_CTRL -- requirements
Module: multi_road_traffic_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_ROADS, default 2, road count (2..8), road 0 is main road; CLK_FREQ, default 50000, clk cycles per tick; GREEN_TIMEOUT, default 20, max green ticks; MIN_GREEN, default 5, min side-road green ticks; YELLOW_TIMEOUT, default 10, yellow ticks; ALL_RED_TIMEOUT, default 2, all-red ticks.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sensor  input  NUM_ROADS  per-road vehicle present, level, bit k = road k (bit 0 ignored).
REQ-005 lights  output  3*NUM_ROADS  per-road lamp, bits [3k+2:3k] = road k, encoding {R,Y,G}: 100 red, 010 yellow, 001 green, 000 off.
REQ-006 active_road  output  $clog2(NUM_ROADS)  index of road currently in green/yellow.
REQ-007 Elaboration SHALL fail unless 1<=MIN_GREEN<=GREEN_TIMEOUT, YELLOW_TIMEOUT>=1, ALL_RED_TIMEOUT>=1, CLK_FREQ>=1.

Function
REQ-008 Prescaler SHALL emit a one-cycle tick every CLK_FREQ cycles; prescaler and tick counter SHALL clear on every state entry, so a state of T ticks lasts exactly T*CLK_FREQ cycles.
REQ-009 States SHALL be GREEN, YELLOW, ALL_RED (plus FLASH, REQ-020); transitions occur on the cycle after the qualifying tick.
REQ-010 Request register: bit k SHALL set on any cycle sensor[k]=1 (k>=1), held until road k enters GREEN, cleared on that entry.
REQ-011 GREEN, road 0: SHALL hold indefinitely while no request pending; leaves to YELLOW when elapsed ticks >= GREEN_TIMEOUT and any request pending.
REQ-012 GREEN, road k>=1: leaves to YELLOW when elapsed = GREEN_TIMEOUT, or earlier (gap-out) when elapsed >= MIN_GREEN and sensor[k]=0.
REQ-013 YELLOW SHALL last YELLOW_TIMEOUT ticks, then ALL_RED for ALL_RED_TIMEOUT ticks.
REQ-014 At ALL_RED exit next road SHALL be first pending request scanning round-robin from active_road+1 upward with wrap; if none, road 0.
REQ-015 Lights: active road shows 001 in GREEN, 010 in YELLOW; every other road and all roads in ALL_RED show 100; never two roads non-red.
REQ-016 Sensor asserted on the active road during its GREEN SHALL NOT set its request bit; during its YELLOW/ALL_RED it SHALL.
REQ-017 Simultaneous requests SHALL each be served once per round-robin pass; no road starves.

Reset
REQ-018 While rst_n=0: state GREEN, active_road 0, lights road 0 = 001, others 100, requests cleared, prescaler and tick counter 0.
REQ-019 Reset asserted mid-operation SHALL force REQ-018 values immediately (asynchronously), abandoning any yellow/all-red.

Configuration
REQ-020 Macro TRAFFIC_FLASH_EN: when defined, adds input flash_req (1 bit); flash_req=1 sampled at ALL_RED exit enters FLASH, where road 0 alternates 010/000 and others 100/000 each tick, starting on; flash_req=0 at a tick leaves FLASH to ALL_RED, then road 0 GREEN; requests keep latching during FLASH.
REQ-021 When TRAFFIC_FLASH_EN is undefined, port flash_req and state FLASH SHALL not exist; behaviour per REQ-008..017 only.

Structure
REQ-022 Shared package traffic_pkg SHALL hold lamp encoding constants (LIGHT_RED, LIGHT_YELLOW, LIGHT_GREEN, LIGHT_OFF) and the state enum.
REQ-023 Prescaler SHALL be sub-module tick_prescaler (params CLK_FREQ; inputs clk, rst_n, clear; output tick).

Verification (NUM_ROADS=3, CLK_FREQ=4, GREEN_TIMEOUT=5, MIN_GREEN=2, YELLOW_TIMEOUT=2, ALL_RED_TIMEOUT=1; t=0 at rst_n release)
REQ-024 No sensors for 200 cycles -> lights = 100_100_001, active_road 0 throughout.
REQ-025 sensor[1] one-cycle pulse at t=3 -> road 0 yellow from t=20, all red t=28, road 1 green t=32, gap-out yellow t=40, road 0 green t=52.
REQ-026 sensor[1] and sensor[2] both high t=3..5 -> green order 0,1,2,0; each side road green exactly MIN_GREEN ticks.
REQ-027 sensor[2] held high -> road 2 green exactly 20 cycles (GREEN_TIMEOUT), then yellow 8, all red 4.
REQ-028 rst_n pulsed low during road 1 yellow -> same cycle lights = 100_100_001, requests cleared.
REQ-029 (TRAFFIC_FLASH_EN) flash_req=1 before an ALL_RED exit -> road 0 toggles 010/000 every 4 cycles, others 100/000; flash_req=0 -> 4 cycles all red, then road 0 green.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_pkg                                                          |
// | Lamp encodings and controller state enum shared by the traffic RTL.  |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  typedef enum logic [1:0] {
    ST_GREEN   = 2'd0,
    ST_YELLOW  = 2'd1,
`ifdef TRAFFIC_FLASH_EN
    ST_FLASH   = 2'd3,
`endif
    ST_ALL_RED = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_prescaler                                                       |
// | One-cycle tick every CLK_FREQ clocks; clear restarts the period.     |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
module tick_prescaler #(
  parameter int CLK_FREQ = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0] c_last = CW'(CLK_FREQ - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/multi_road_traffic_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_road_traffic_ctrl                                              |
// | Round-robin traffic light controller, road 0 is the main road.       |
// | Optional flashing mode: define TRAFFIC_FLASH_EN.                     |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
module multi_road_traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_ROADS       = 2,
  parameter int CLK_FREQ        = 50000,
  parameter int GREEN_TIMEOUT   = 20,
  parameter int MIN_GREEN       = 5,
  parameter int YELLOW_TIMEOUT  = 10,
  parameter int ALL_RED_TIMEOUT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_ROADS-1:0]         sensor,
`ifdef TRAFFIC_FLASH_EN
  input  logic                         flash_req,
`endif
  output logic [3*NUM_ROADS-1:0]       lights,
  output logic [$clog2(NUM_ROADS)-1:0] active_road
);

  localparam int RW   = $clog2(NUM_ROADS);
  localparam int TMAX = (GREEN_TIMEOUT > YELLOW_TIMEOUT)
                        ? ((GREEN_TIMEOUT > ALL_RED_TIMEOUT) ? GREEN_TIMEOUT : ALL_RED_TIMEOUT)
                        : ((YELLOW_TIMEOUT > ALL_RED_TIMEOUT) ? YELLOW_TIMEOUT : ALL_RED_TIMEOUT);
  localparam int TW   = $clog2(TMAX + 2);

  localparam logic [TW-1:0] c_tmax     = TW'(TMAX);
  localparam logic [TW-1:0] c_green_to = TW'(GREEN_TIMEOUT);
  localparam logic [TW-1:0] c_min_grn  = TW'(MIN_GREEN);
  localparam logic [TW-1:0] c_yel_to   = TW'(YELLOW_TIMEOUT);
  localparam logic [TW-1:0] c_red_to   = TW'(ALL_RED_TIMEOUT);
  localparam logic [3*NUM_ROADS-1:0] c_lights_rst = {{(NUM_ROADS-1){LIGHT_RED}}, LIGHT_GREEN};

  if (NUM_ROADS < 2 || NUM_ROADS > 8 || MIN_GREEN < 1 || MIN_GREEN > GREEN_TIMEOUT ||
      YELLOW_TIMEOUT < 1 || ALL_RED_TIMEOUT < 1 || CLK_FREQ < 1) begin : g_bad_params
    $error("multi_road_traffic_ctrl: illegal parameter set");
  end

  state_t                 r_state, w_state_nxt;
  logic [RW-1:0]          r_road, w_road_nxt, w_scan_road;
  logic [NUM_ROADS-1:0]   r_req, w_req_nxt, w_green_mask, w_clr_mask;
  logic [TW-1:0]          r_ticks, w_elapsed;
  logic [3*NUM_ROADS-1:0] r_lights, w_lights_nxt;
  logic                   w_enter, w_tick;
  int                     w_best_dist, w_dist;
`ifdef TRAFFIC_FLASH_EN
  logic r_flash_on, w_flash_nxt, r_after_flash, w_after_flash_nxt;
`endif

  tick_prescaler #(.CLK_FREQ(CLK_FREQ)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_enter),
    .tick  (w_tick)
  );

  always_comb begin
    w_elapsed   = r_ticks + 1'b1;
    w_state_nxt = r_state;
    w_road_nxt  = r_road;
    w_enter     = 1'b0;
`ifdef TRAFFIC_FLASH_EN
    w_flash_nxt       = r_flash_on;
    w_after_flash_nxt = r_after_flash;
`endif
    // Nearest pending road after the active one; the active road itself is last.
    w_scan_road = '0;
    w_best_dist = NUM_ROADS + 1;
    w_dist      = 0;
    for (int k = 0; k < NUM_ROADS; k++) begin
      w_dist = (k > int'(r_road)) ? (k - int'(r_road)) : (k + NUM_ROADS - int'(r_road));
      if (r_req[k] && w_dist < w_best_dist) begin
        w_best_dist = w_dist;
        w_scan_road = RW'(k);
      end
    end

    case (r_state)
      ST_GREEN: begin
        if (w_tick) begin
          if (r_road == '0) begin
            if (w_elapsed >= c_green_to && |r_req) begin
              w_state_nxt = ST_YELLOW;
              w_enter     = 1'b1;
            end
          end else if (w_elapsed >= c_green_to ||
                       (w_elapsed >= c_min_grn && !sensor[r_road])) begin
            w_state_nxt = ST_YELLOW;
            w_enter     = 1'b1;
          end
        end
      end
      ST_YELLOW: begin
        if (w_tick && w_elapsed >= c_yel_to) begin
          w_state_nxt = ST_ALL_RED;
          w_enter     = 1'b1;
        end
      end
      ST_ALL_RED: begin
        if (w_tick && w_elapsed >= c_red_to) begin
          w_enter = 1'b1;
`ifdef TRAFFIC_FLASH_EN
          if (flash_req) begin
            w_state_nxt = ST_FLASH;
            w_road_nxt  = '0;
            w_flash_nxt = 1'b1;
          end else begin
            w_state_nxt       = ST_GREEN;
            w_road_nxt        = r_after_flash ? '0 : w_scan_road;
            w_after_flash_nxt = 1'b0;
          end
`else
          w_state_nxt = ST_GREEN;
          w_road_nxt  = w_scan_road;
`endif
        end
      end
`ifdef TRAFFIC_FLASH_EN
      ST_FLASH: begin
        if (w_tick) begin
          if (!flash_req) begin
            w_state_nxt       = ST_ALL_RED;
            w_enter           = 1'b1;
            w_after_flash_nxt = 1'b1;
          end else begin
            w_flash_nxt = ~r_flash_on;
          end
        end
      end
`endif
      default: begin
        w_state_nxt = ST_GREEN;
        w_road_nxt  = '0;
        w_enter     = 1'b1;
      end
    endcase

    // The road being served never latches its own sensor while green.
    w_green_mask = (r_state == ST_GREEN) ? (NUM_ROADS'(1) << r_road) : '0;
    w_clr_mask   = (w_enter && w_state_nxt == ST_GREEN) ? (NUM_ROADS'(1) << w_road_nxt) : '0;
    w_req_nxt    = (r_req | (sensor & ~w_green_mask)) & ~w_clr_mask;
    w_req_nxt[0] = 1'b0;
  end

  always_comb begin
    w_lights_nxt = '0;
    for (int k = 0; k < NUM_ROADS; k++) begin
      w_lights_nxt[3*k +: 3] = LIGHT_RED;
      if (w_road_nxt == RW'(k)) begin
        if (w_state_nxt == ST_GREEN) begin
          w_lights_nxt[3*k +: 3] = LIGHT_GREEN;
        end else if (w_state_nxt == ST_YELLOW) begin
          w_lights_nxt[3*k +: 3] = LIGHT_YELLOW;
        end
      end
`ifdef TRAFFIC_FLASH_EN
      if (w_state_nxt == ST_FLASH) begin
        w_lights_nxt[3*k +: 3] = !w_flash_nxt ? LIGHT_OFF : ((k == 0) ? LIGHT_YELLOW : LIGHT_RED);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_GREEN;
      r_road   <= '0;
      r_req    <= '0;
      r_ticks  <= '0;
      r_lights <= c_lights_rst;
`ifdef TRAFFIC_FLASH_EN
      r_flash_on    <= 1'b0;
      r_after_flash <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_road   <= w_road_nxt;
      r_req    <= w_req_nxt;
      r_lights <= w_lights_nxt;
      if (w_enter) begin
        r_ticks <= '0;
      end else if (w_tick && r_ticks != c_tmax) begin
        r_ticks <= r_ticks + 1'b1;
      end
`ifdef TRAFFIC_FLASH_EN
      r_flash_on    <= w_flash_nxt;
      r_after_flash <= w_after_flash_nxt;
`endif
    end
  end

  assign lights      = r_lights;
  assign active_road = r_road;

endmodule
`default_nettype wire

// File: tb/tb_multi_road_traffic_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multi_road_traffic_ctrl                                           |
// | Directed timeline checks for the 3-road controller, 4 clocks/tick.   |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
module tb_multi_road_traffic_ctrl;

  localparam logic [8:0] c_r0g  = 9'b100_100_001;
  localparam logic [8:0] c_r0y  = 9'b100_100_010;
  localparam logic [8:0] c_r1g  = 9'b100_001_100;
  localparam logic [8:0] c_r1y  = 9'b100_010_100;
  localparam logic [8:0] c_r2g  = 9'b001_100_100;
  localparam logic [8:0] c_r2y  = 9'b010_100_100;
  localparam logic [8:0] c_allr = 9'b100_100_100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sensor = 3'b000;
  logic       flash_req = 1'b0;
  logic [8:0] lights;
  logic [1:0] active_road;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  multi_road_traffic_ctrl #(
    .NUM_ROADS(3), .CLK_FREQ(4), .GREEN_TIMEOUT(5), .MIN_GREEN(2),
    .YELLOW_TIMEOUT(2), .ALL_RED_TIMEOUT(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sensor      (sensor),
`ifdef TRAFFIC_FLASH_EN
    .flash_req   (flash_req),
`endif
    .lights      (lights),
    .active_road (active_road)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got[8:0], exp[8:0]);
    end
  endtask

  // Advance to the negedge inside cycle t (t=0 is the cycle rst_n is released).
  task automatic at(input int t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_at(input int t, input string tag, input logic [8:0] exp_l, input int exp_a);
    at(t);
    chk($sformatf("%s_lights@%0d", tag, t), 32'(lights), 32'(exp_l));
    if (exp_a >= 0) chk($sformatf("%s_road@%0d", tag, t), 32'(active_road), 32'(exp_a));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    sensor    = 3'b000;
    flash_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic pulse(input int t, input logic [2:0] s);
    at(t);
    sensor = s;
    at(t + 1);
    sensor = 3'b000;
  endtask

  initial begin
    // Idle: sensor[0] is ignored, main road holds green.
    do_reset();
    sensor = 3'b001;
    for (int t = 0; t <= 200; t += 10) chk_at(t, "idle", c_r0g, 0);

    // Single side request with gap-out; own sensor during green is not latched.
    do_reset();
    pulse(3, 3'b010);
    chk_at(19, "s1", c_r0g, 0);
    chk_at(20, "s1", c_r0y, 0);
    chk_at(27, "s1", c_r0y, 0);
    chk_at(28, "s1", c_allr, -1);
    chk_at(31, "s1", c_allr, -1);
    chk_at(32, "s1", c_r1g, 1);
    pulse(33, 3'b010);
    chk_at(39, "s1", c_r1g, 1);
    chk_at(40, "s1", c_r1y, 1);
    chk_at(47, "s1", c_r1y, 1);
    chk_at(48, "s1", c_allr, -1);
    chk_at(52, "s1", c_r0g, 0);
    chk_at(80, "s1", c_r0g, 0);

    // Own sensor during yellow is latched and road 1 is served again.
    do_reset();
    pulse(3, 3'b010);
    pulse(44, 3'b010);
    chk_at(52, "s1y", c_r1g, 1);
    chk_at(60, "s1y", c_r1y, 1);
    chk_at(72, "s1y", c_r0g, 0);

    // Two simultaneous requests: order 0,1,2,0 with MIN_GREEN each.
    do_reset();
    at(3);
    sensor = 3'b110;
    at(6);
    sensor = 3'b000;
    chk_at(32, "rr", c_r1g, 1);
    chk_at(39, "rr", c_r1g, 1);
    chk_at(40, "rr", c_r1y, 1);
    chk_at(51, "rr", c_allr, -1);
    chk_at(52, "rr", c_r2g, 2);
    chk_at(59, "rr", c_r2g, 2);
    chk_at(60, "rr", c_r2y, 2);
    chk_at(68, "rr", c_allr, -1);
    chk_at(72, "rr", c_r0g, 0);

    // Held sensor: road 2 runs to GREEN_TIMEOUT.
    do_reset();
    at(3);
    sensor = 3'b100;
    chk_at(31, "max", c_allr, -1);
    chk_at(32, "max", c_r2g, 2);
    chk_at(51, "max", c_r2g, 2);
    chk_at(52, "max", c_r2y, 2);
    sensor = 3'b000;
    chk_at(59, "max", c_r2y, 2);
    chk_at(60, "max", c_allr, -1);
    chk_at(63, "max", c_allr, -1);
    chk_at(64, "max", c_r0g, 0);

    // Asynchronous reset during road 1 yellow drops the pending road 2 request.
    do_reset();
    pulse(3, 3'b010);
    pulse(34, 3'b100);
    chk_at(42, "arst", c_r1y, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lights_now", 32'(lights), 32'(c_r0g));
    chk("arst_road_now", 32'(active_road), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    chk_at(25, "arst", c_r0g, 0);
    chk_at(40, "arst", c_r0g, 0);

`ifdef TRAFFIC_FLASH_EN
    do_reset();
    flash_req = 1'b1;
    pulse(3, 3'b010);
    chk_at(32, "fl", c_r0y, 0);
    chk_at(35, "fl", c_r0y, 0);
    chk_at(36, "fl", 9'b000_000_000, 0);
    chk_at(39, "fl", 9'b000_000_000, 0);
    chk_at(40, "fl", c_r0y, 0);
    at(41);
    flash_req = 1'b0;
    chk_at(44, "fl", c_allr, -1);
    chk_at(47, "fl", c_allr, -1);
    chk_at(48, "fl", c_r0g, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
